multicycle_ctrl: RTL and testbench

- Control FSM for the multicycle CPU.
- Sequences each instruction through FETCH, DECODE, EXEC, MEM and WB.
- Drives the ALU `op_code`, the datapath mux selects and the register/memory write strobes from the IR opcode field.
- Samples the ALU `zero` flag and the memory `mem_ready` handshake, so this block is the issuing end of the ALU op_code interface.

---
 rtl/multicycle_ctrl_pkg.sv | 72 +++++++
 rtl/multicycle_ctrl_if.sv | 41 ++++
 rtl/multicycle_ctrl_decode.sv | 135 +++++++++++++
 rtl/multicycle_ctrl.sv | 81 ++++++++
 tb/tb_multicycle_ctrl.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle CPU control path:
// FSM states, opcodes, ALU ops, mux selects and the control bundle.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_JMP  = 4'b1000;
  localparam logic [3:0] OP_LI   = 4'b1001;
  localparam logic [3:0] OP_LW   = 4'b1010;
  localparam logic [3:0] OP_LWI  = 4'b1011;
  localparam logic [3:0] OP_SWI  = 4'b1100;
  localparam logic [3:0] OP_SW   = 4'b1101;
  localparam logic [3:0] OP_BEQ  = 4'b1110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_LI  = 4'b1001;
  localparam logic [3:0] ALU_LWI = 4'b1011;
  localparam logic [3:0] ALU_SWI = 4'b1100;

  localparam logic       SRC_A_REG = 1'b0;
  localparam logic       SRC_A_PC  = 1'b1;

  localparam logic [1:0] SRC_B_REG = 2'b00;
  localparam logic [1:0] SRC_B_ONE = 2'b01;
  localparam logic [1:0] SRC_B_IMM = 2'b10;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic       ADDR_PC     = 1'b0;
  localparam logic       ADDR_ALUOUT = 1'b1;

  typedef struct packed {
    logic [3:0] op_code;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mdr_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
  } ctrl_t;

  function automatic logic is_rtype(input logic [3:0] op);
    return ~op[3];
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    return (op == OP_LW) || (op == OP_LWI);
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    return (op == OP_SW) || (op == OP_SWI);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// Control-path bundle between the sequencer and the datapath.
// master = controller (drives strobes), slave = datapath/memory side.
interface multicycle_ctrl_if;
  logic [3:0] instr_op;
  logic       zero;
  logic       mem_ready;
  logic [3:0] op_code;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       pc_write;
  logic [1:0] pc_src;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       mdr_write;
  logic       alu_out_write;
  logic       reg_write;
  logic       mem_to_reg;
  logic       halted;
  logic       mem_timeout;
  logic [2:0] state;

  modport master (
    input  instr_op, zero, mem_ready,
    output op_code, alu_src_a, alu_src_b,
    output pc_write, pc_src, ir_write, i_or_d,
    output mem_read, mem_write, mdr_write,
    output alu_out_write, reg_write, mem_to_reg,
    output halted, mem_timeout, state
  );

  modport slave (
    output instr_op, zero, mem_ready,
    input  op_code, alu_src_a, alu_src_b,
    input  pc_write, pc_src, ir_write, i_or_d,
    input  mem_read, mem_write, mdr_write,
    input  alu_out_write, reg_write, mem_to_reg,
    input  halted, mem_timeout, state
  );
endinterface

// File: rtl/multicycle_ctrl_decode.sv
// Combinational next-state and control-strobe decode.
// In: state, instr_op, zero, mem_ready. Out: ctl bundle, nxt state.
import ctrl_pkg::*;

module ctrl_decode (
  input  state_e     state,
  input  logic [3:0] instr_op,
  input  logic       zero,
  input  logic       mem_ready,
  output ctrl_t      ctl,
  output state_e     nxt
);

  logic rtype;
  logic ld;
  logic st;

  assign rtype = is_rtype(instr_op);
  assign ld    = is_load(instr_op);
  assign st    = is_store(instr_op);

  always_comb begin
    nxt = ST_FETCH;
    case (state)
      ST_FETCH:
        nxt = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE:
        unique case (1'b1)
          instr_op == OP_JMP:  nxt = ST_FETCH;
          instr_op == OP_HALT: nxt = ST_HALT;
          default:             nxt = ST_EXEC;
        endcase
      ST_EXEC:
        unique case (1'b1)
          rtype,
          instr_op == OP_LI: nxt = ST_WB;
          ld, st:            nxt = ST_MEM;
          default:           nxt = ST_FETCH;
        endcase
      ST_MEM:
        if (!mem_ready)
          nxt = ST_MEM;
        else
          nxt = ld ? ST_WB : ST_FETCH;
      ST_WB:
        nxt = ST_FETCH;
      ST_HALT:
        nxt = ST_HALT;
      default:
        nxt = ST_FETCH;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      ST_FETCH: begin
        ctl.mem_read = 1'b1;
        ctl.i_or_d   = ADDR_PC;
        if (mem_ready) begin
          ctl.ir_write  = 1'b1;
          ctl.pc_write  = 1'b1;
          ctl.pc_src    = PC_SRC_ALU;
          ctl.alu_src_a = SRC_A_PC;
          ctl.alu_src_b = SRC_B_ONE;
          ctl.op_code   = ALU_ADD;
        end
      end
      ST_DECODE: begin
        // speculative branch target PC + imm
        ctl.alu_src_a     = SRC_A_PC;
        ctl.alu_src_b     = SRC_B_IMM;
        ctl.op_code       = ALU_ADD;
        ctl.alu_out_write = 1'b1;
        if (instr_op == OP_JMP) begin
          ctl.pc_write = 1'b1;
          ctl.pc_src   = PC_SRC_JUMP;
        end
      end
      ST_EXEC:
        unique case (1'b1)
          rtype: begin
            ctl.op_code       = instr_op;
            ctl.alu_src_b     = SRC_B_REG;
            ctl.alu_out_write = 1'b1;
          end
          instr_op == OP_LI: begin
            ctl.op_code       = ALU_LI;
            ctl.alu_src_b     = SRC_B_IMM;
            ctl.alu_out_write = 1'b1;
          end
          instr_op == OP_LW,
          instr_op == OP_SW: begin
            ctl.op_code       = ALU_ADD;
            ctl.alu_src_a     = SRC_A_REG;
            ctl.alu_src_b     = SRC_B_IMM;
            ctl.alu_out_write = 1'b1;
          end
          instr_op == OP_LWI: begin
            ctl.op_code       = ALU_LWI;
            ctl.alu_src_b     = SRC_B_IMM;
            ctl.alu_out_write = 1'b1;
          end
          instr_op == OP_SWI: begin
            ctl.op_code       = ALU_SWI;
            ctl.alu_src_b     = SRC_B_IMM;
            ctl.alu_out_write = 1'b1;
          end
          instr_op == OP_BEQ: begin
            // ALUOut still holds the DECODE target
            ctl.op_code   = ALU_SUB;
            ctl.alu_src_a = SRC_A_REG;
            ctl.alu_src_b = SRC_B_REG;
            ctl.pc_write  = zero;
            ctl.pc_src    = PC_SRC_ALUOUT;
          end
          default: ;
        endcase
      ST_MEM: begin
        ctl.i_or_d    = ADDR_ALUOUT;
        ctl.mem_read  = ld;
        ctl.mem_write = st;
        ctl.mdr_write = ld & mem_ready;
      end
      ST_WB: begin
        ctl.reg_write  = 1'b1;
        ctl.mem_to_reg = ld;
      end
      ST_HALT:
        ctl.halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle CPU sequencer: state register, memory wait watchdog
// and sticky timeout flag; strobes come from ctrl_decode.
import ctrl_pkg::*;

module multicycle_ctrl #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input logic             clk,
  input logic             rst,
  multicycle_ctrl_if.master bus
);

  localparam int unsigned CW =
    (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1;

  state_e          state_q;
  state_e          dec_nxt;
  state_e          nxt;
  logic [CW-1:0]   wait_q;
  logic            timeout_q;
  logic            waiting;
  logic            wait_hit;
  ctrl_t           ctl;
  ctrl_t           out;

  ctrl_decode u_dec (
    .state     (state_q),
    .instr_op  (bus.instr_op),
    .zero      (bus.zero),
    .mem_ready (bus.mem_ready),
    .ctl       (ctl),
    .nxt       (dec_nxt)
  );

  assign waiting = ((state_q == ST_FETCH) ||
                    (state_q == ST_MEM)) &&
                   !bus.mem_ready;

  // wait_q counts earlier stalled cycles, so this fires on
  // the WAIT_LIMIT-th cycle without mem_ready
  assign wait_hit = (WAIT_LIMIT != 0) && waiting &&
                    (32'(wait_q) + 32'd1 == WAIT_LIMIT);

  assign nxt = wait_hit ? ST_HALT : dec_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q <= nxt;
      if (wait_hit)
        timeout_q <= 1'b1;
      if (waiting && (nxt == state_q))
        wait_q <= wait_q + 1'b1;
      else
        wait_q <= '0;
    end
  end

  assign out = rst ? '0 : ctl;

  assign bus.op_code       = out.op_code;
  assign bus.alu_src_a     = out.alu_src_a;
  assign bus.alu_src_b     = out.alu_src_b;
  assign bus.pc_write      = out.pc_write;
  assign bus.pc_src        = out.pc_src;
  assign bus.ir_write      = out.ir_write;
  assign bus.i_or_d        = out.i_or_d;
  assign bus.mem_read      = out.mem_read;
  assign bus.mem_write     = out.mem_write;
  assign bus.mdr_write     = out.mdr_write;
  assign bus.alu_out_write = out.alu_out_write;
  assign bus.reg_write     = out.reg_write;
  assign bus.mem_to_reg    = out.mem_to_reg;
  assign bus.halted        = out.halted;
  assign bus.mem_timeout   = timeout_q & ~rst;
  assign bus.state         = rst ? 3'd0 : state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: instruction-level expansion model,
// per-cycle compare plus literal cycles-per-instruction checks.
module tb_multicycle_ctrl;

  localparam int unsigned WL = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.WAIT_LIMIT(WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] op_code;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       pc_write;
    logic [1:0] pc_src;
    logic       ir_write;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       mdr_write;
    logic       alu_out_write;
    logic       reg_write;
    logic       mem_to_reg;
    logic       halted;
    logic       mem_timeout;
    logic [2:0] state;
  } exp_t;

  exp_t  exp_v;
  logic  chk_en = 1'b0;
  string tag = "none";
  int    checks = 0;
  int    failures = 0;
  int    ncyc = 0;

  function automatic logic ld_op(input logic [3:0] op);
    return op == 4'hA || op == 4'hB;
  endfunction

  function automatic logic st_op(input logic [3:0] op);
    return op == 4'hC || op == 4'hD;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic exp_t v_fetch(input logic rdy);
    exp_t e = '0;
    e.mem_read = 1'b1;
    if (rdy) begin
      e.ir_write  = 1'b1;
      e.pc_write  = 1'b1;
      e.alu_src_a = 1'b1;
      e.alu_src_b = 2'b01;
      e.op_code   = 4'b0010;
    end
    return e;
  endfunction

  function automatic exp_t v_decode(input logic [3:0] op);
    exp_t e = '0;
    e.state         = 3'd1;
    e.alu_src_a     = 1'b1;
    e.alu_src_b     = 2'b10;
    e.op_code       = 4'b0010;
    e.alu_out_write = 1'b1;
    if (op == 4'h8) begin
      e.pc_write = 1'b1;
      e.pc_src   = 2'b10;
    end
    return e;
  endfunction

  function automatic exp_t v_exec(input logic [3:0] op,
                                  input logic z);
    exp_t e = '0;
    e.state = 3'd2;
    if (op < 4'h8) begin
      e.op_code = op;
      e.alu_out_write = 1'b1;
    end else if (op == 4'h9 || op == 4'hB || op == 4'hC) begin
      e.op_code = op;
      e.alu_src_b = 2'b10;
      e.alu_out_write = 1'b1;
    end else if (op == 4'hA || op == 4'hD) begin
      e.op_code = 4'b0010;
      e.alu_src_b = 2'b10;
      e.alu_out_write = 1'b1;
    end else if (op == 4'hE) begin
      e.op_code  = 4'b0011;
      e.pc_write = z;
      e.pc_src   = 2'b01;
    end
    return e;
  endfunction

  function automatic exp_t v_mem(input logic [3:0] op,
                                 input logic rdy);
    exp_t e = '0;
    e.state     = 3'd3;
    e.i_or_d    = 1'b1;
    e.mem_read  = ld_op(op);
    e.mem_write = st_op(op);
    e.mdr_write = ld_op(op) && rdy;
    return e;
  endfunction

  function automatic exp_t v_wb(input logic [3:0] op);
    exp_t e = '0;
    e.state      = 3'd4;
    e.reg_write  = 1'b1;
    e.mem_to_reg = ld_op(op);
    return e;
  endfunction

  function automatic exp_t v_halt(input logic to);
    exp_t e = '0;
    e.state       = 3'd5;
    e.halted      = 1'b1;
    e.mem_timeout = to;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t a;
    if (chk_en) begin
      a = {bus.op_code, bus.alu_src_a, bus.alu_src_b,
           bus.pc_write, bus.pc_src, bus.ir_write,
           bus.i_or_d, bus.mem_read, bus.mem_write,
           bus.mdr_write, bus.alu_out_write,
           bus.reg_write, bus.mem_to_reg, bus.halted,
           bus.mem_timeout, bus.state};
      checks++;
      if (a !== exp_v) begin
        failures++;
        $display("FAIL %s cyc=%0d op=%h got=%h want=%h",
                 tag, ncyc, bus.instr_op, a, exp_v);
      end
    end
  end

  task automatic cyc(input string t, input logic r,
                     input logic rdy, input logic z,
                     input logic [3:0] op, input exp_t e);
    rst           = r;
    bus.mem_ready = rdy;
    bus.zero      = z;
    bus.instr_op  = op;
    exp_v         = e;
    tag           = t;
    chk_en        = 1'b1;
    ncyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic halt_and_reset(input logic to,
                                input logic [3:0] op);
    repeat ($urandom_range(1, 3))
      cyc("halt", 1'b0, rb(), rb(), op, v_halt(to));
    repeat ($urandom_range(1, 2))
      cyc("reset", 1'b1, rb(), rb(), 4'($urandom), '0);
  endtask

  task automatic do_instr(input logic [3:0] op, input int fw,
                          input int mw, input logic z);
    for (int i = 0; i < fw; i++) begin
      cyc("fetch_wait", 1'b0, 1'b0, rb(), 4'($urandom),
          v_fetch(1'b0));
      if (i == int'(WL) - 1) begin
        halt_and_reset(1'b1, op);
        return;
      end
    end
    cyc("fetch", 1'b0, 1'b1, rb(), 4'($urandom), v_fetch(1'b1));
    cyc("decode", 1'b0, rb(), rb(), op, v_decode(op));
    if (op == 4'h8) return;
    if (op == 4'hF) begin
      halt_and_reset(1'b0, op);
      return;
    end
    cyc("exec", 1'b0, rb(), z, op, v_exec(op, z));
    if (op == 4'hE) return;
    if (ld_op(op) || st_op(op)) begin
      for (int i = 0; i < mw; i++) begin
        cyc("mem_wait", 1'b0, 1'b0, rb(), op, v_mem(op, 1'b0));
        if (i == int'(WL) - 1) begin
          halt_and_reset(1'b1, op);
          return;
        end
      end
      cyc("mem", 1'b0, 1'b1, rb(), op, v_mem(op, 1'b1));
      if (st_op(op)) return;
    end
    cyc("wb", 1'b0, rb(), rb(), op, v_wb(op));
  endtask

  // zero-wait cycles from FETCH back to FETCH (or into HALT)
  task automatic cpi(input logic [3:0] op, input int want);
    int n;
    chk_en        = 1'b0;
    rst           = 1'b0;
    bus.instr_op  = op;
    bus.mem_ready = 1'b1;
    bus.zero      = 1'b0;
    n = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.state == 3'd0 || bus.state == 3'd5) break;
    end
    checks++;
    if (n != want) begin
      failures++;
      $display("FAIL cpi_op%h got=%0d want=%0d", op, n, want);
    end
  endtask

  initial begin
    logic [3:0] op;
    int fw;
    int mw;
    bus.instr_op  = 4'h0;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    rst           = 1'b1;
    @(posedge clk);
    #1;
    cyc("reset", 1'b1, 1'b1, 1'b0, 4'h0, '0);
    cyc("reset", 1'b1, 1'b1, 1'b0, 4'h0, '0);

    do_instr(4'h2, 0, 0, 1'b0);
    do_instr(4'hA, 0, 3, 1'b0);
    do_instr(4'hE, 0, 0, 1'b1);
    do_instr(4'hE, 0, 0, 1'b0);
    do_instr(4'hC, 0, 0, 1'b0);
    do_instr(4'h8, 0, 0, 1'b0);
    do_instr(4'hB, 2, 1, 1'b0);
    do_instr(4'hD, 3, 3, 1'b0);
    do_instr(4'h5, 0, 0, 1'b0);
    do_instr(4'h3, 5, 0, 1'b0);
    do_instr(4'hF, 0, 0, 1'b0);
    do_instr(4'hA, 0, 4, 1'b0);

    cyc("fetch", 1'b0, 1'b1, 1'b0, 4'h0, v_fetch(1'b1));
    cyc("decode", 1'b0, 1'b0, 1'b0, 4'hA, v_decode(4'hA));
    cyc("exec", 1'b0, 1'b1, 1'b0, 4'hA, v_exec(4'hA, 1'b0));
    cyc("mem_wait", 1'b0, 1'b0, 1'b0, 4'hA,
        v_mem(4'hA, 1'b0));
    cyc("reset", 1'b1, 1'b0, 1'b0, 4'hA, '0);

    cpi(4'h8, 2);
    cpi(4'hE, 3);
    cpi(4'h2, 4);
    cpi(4'h9, 4);
    cpi(4'hD, 4);
    cpi(4'hC, 4);
    cpi(4'hA, 5);
    cpi(4'hB, 5);
    cpi(4'hF, 2);
    cyc("reset", 1'b1, 1'b1, 1'b0, 4'h0, '0);

    for (int k = 0; k < 400; k++) begin
      op = 4'($urandom);
      if (op == 4'hF && $urandom_range(0, 3) != 0)
        op = 4'h2;
      fw = ($urandom_range(0, 4) == 0) ?
           int'($urandom_range(1, 5)) : 0;
      mw = ($urandom_range(0, 2) == 0) ?
           int'($urandom_range(1, 5)) : 0;
      do_instr(op, fw, mw, rb());
    end

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
